rr_grant_scheduler: RTL and testbench

- Four-agent round-robin grant scheduler with bounded hold time. Shares a single resource between agents 0..3.
- Replaces fixed-priority grant logic, so a persistent low-index requester cannot starve the others.
- Sits between the agent request lines and the shared resource; it drives one-hot grants and an encoded owner id.

---
 rtl/rr_sched_pkg.sv | 13 +
 rtl/rr_grant_scheduler_if.sv | 40 ++++
 rtl/rr_pick4.sv | 27 ++
 rtl/rr_grant_scheduler.sv | 130 +++++++++++++
 tb/tb_rr_grant_scheduler.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/rr_sched_pkg.sv
// Shared constants and state encoding for the four-agent round-robin grant scheduler.
package rr_sched_pkg;

    localparam int unsigned NUM_AGENTS = 4;
    localparam int unsigned AGENT_W    = 2;
    localparam int unsigned PCNT_W     = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_e;

endpackage

// File: rtl/rr_grant_scheduler_if.sv
// Request/grant bundle between the agents (master) and the scheduler (slave).
// preempt_cnt exists only when RR_PREEMPT_STATS_EN is defined.
interface rr_grant_scheduler_if;
    import rr_sched_pkg::*;

    logic               req_0;
    logic               req_1;
    logic               req_2;
    logic               req_3;
    logic               gnt_0;
    logic               gnt_1;
    logic               gnt_2;
    logic               gnt_3;
    logic               gnt_valid;
    logic [AGENT_W-1:0] gnt_id;
`ifdef RR_PREEMPT_STATS_EN
    logic [PCNT_W-1:0]  preempt_cnt;
`endif

`ifdef RR_PREEMPT_STATS_EN
    modport master (
        output req_0, req_1, req_2, req_3,
        input  gnt_0, gnt_1, gnt_2, gnt_3, gnt_valid, gnt_id, preempt_cnt
    );
    modport slave (
        input  req_0, req_1, req_2, req_3,
        output gnt_0, gnt_1, gnt_2, gnt_3, gnt_valid, gnt_id, preempt_cnt
    );
`else
    modport master (
        output req_0, req_1, req_2, req_3,
        input  gnt_0, gnt_1, gnt_2, gnt_3, gnt_valid, gnt_id
    );
    modport slave (
        input  req_0, req_1, req_2, req_3,
        output gnt_0, gnt_1, gnt_2, gnt_3, gnt_valid, gnt_id
    );
`endif

endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first requester found scanning last+1, last+2, ... mod 4.
module rr_pick4
    import rr_sched_pkg::*;
(
    input  logic [NUM_AGENTS-1:0] req,
    input  logic [AGENT_W-1:0]    last,
    output logic                  found,
    output logic [AGENT_W-1:0]    winner
);

    logic [AGENT_W-1:0] idx;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        // i == NUM_AGENTS wraps back to last itself, which is scanned last
        for (int unsigned i = 1; i <= NUM_AGENTS; i++) begin
            idx = AGENT_W'(last + AGENT_W'(i));
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Four-agent round-robin grant scheduler with bounded hold time and a forced idle gap between owners.
// Define RR_PREEMPT_STATS_EN to add a saturating preemption counter (preempt_cnt).
module rr_grant_scheduler
    import rr_sched_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned HOLD_W   = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    rr_grant_scheduler_if.slave  bus
);

    sched_state_e          state_q, state_d;
    logic [AGENT_W-1:0]    last_q, last_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [NUM_AGENTS-1:0] gnt_q, gnt_d;
    logic [AGENT_W-1:0]    id_q, id_d;
    logic                  valid_q, valid_d;
    logic [NUM_AGENTS-1:0] req_c;
    logic                  found_c;
    logic [AGENT_W-1:0]    winner_c;
    logic                  others_c;
    logic                  preempt_c;

    assign req_c    = {bus.req_3, bus.req_2, bus.req_1, bus.req_0};
    assign others_c = |(req_c & ~gnt_q);

    rr_pick4 u_pick (
        .req    (req_c),
        .last   (last_q),
        .found  (found_c),
        .winner (winner_c)
    );

    // Next-state: arbitrate in IDLE, hold or release in GRANT.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        valid_d   = valid_q;
        preempt_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (found_c) begin
                    state_d = GRANT;
                    gnt_d   = NUM_AGENTS'(1) << winner_c;
                    id_d    = winner_c;
                    valid_d = 1'b1;
                    last_d  = winner_c;
                    hold_d  = HOLD_W'(1);
                end
            end
            GRANT: begin
                if (!req_c[id_q] ||
                    ((MAX_HOLD != 0) && (hold_q == HOLD_W'(MAX_HOLD)) && others_c)) begin
                    // Release; last keeps the old owner so it ranks lowest next round
                    preempt_c = req_c[id_q];
                    state_d   = IDLE;
                    gnt_d     = '0;
                    id_d      = '0;
                    valid_d   = 1'b0;
                    hold_d    = '0;
                end else if (hold_q < HOLD_W'(MAX_HOLD)) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                id_d    = '0;
                valid_d = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= AGENT_W'(NUM_AGENTS - 1);
            hold_q  <= '0;
            gnt_q   <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            valid_q <= valid_d;
        end
    end

    assign bus.gnt_0     = gnt_q[0];
    assign bus.gnt_1     = gnt_q[1];
    assign bus.gnt_2     = gnt_q[2];
    assign bus.gnt_3     = gnt_q[3];
    assign bus.gnt_valid = valid_q;
    assign bus.gnt_id    = id_q;

`ifdef RR_PREEMPT_STATS_EN
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;

    // Saturating count of preemption releases.
    always_comb begin
        pcnt_d = pcnt_q;
        if (preempt_c && (pcnt_q != {PCNT_W{1'b1}})) begin
            pcnt_d = pcnt_q + PCNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    assign bus.preempt_cnt = pcnt_q;
`else
    logic unused_preempt;
    assign unused_preempt = preempt_c;
`endif

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Bench for rr_grant_scheduler: directed scenarios plus random traffic on a MAX_HOLD=8 and a MAX_HOLD=0 instance.
module tb_rr_grant_scheduler;

    logic clock;
    logic reset;

    rr_grant_scheduler_if if8 ();
    rr_grant_scheduler_if if0 ();

    rr_grant_scheduler #(.MAX_HOLD(8), .HOLD_W(4)) dut8 (
        .clock (clock),
        .reset (reset),
        .bus   (if8.slave)
    );

    rr_grant_scheduler #(.MAX_HOLD(0), .HOLD_W(4)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (if0.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: owner index (-1 = none), last winner, cycles held, preemption count.
    int m_owner [2];
    int m_last  [2];
    int m_held  [2];
    int m_pc    [2];
    int m_max   [2] = '{8, 0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input bit rst_v, input logic [3:0] r);
        if (!rst_v) begin
            m_owner[k] = -1;
            m_last[k]  = 3;
            m_held[k]  = 0;
            m_pc[k]    = 0;
        end else if (m_owner[k] < 0) begin
            for (int i = 1; i <= 4; i++) begin
                int a;
                a = (m_last[k] + i) % 4;
                if (m_owner[k] < 0 && r[a]) begin
                    m_owner[k] = a;
                    m_last[k]  = a;
                    m_held[k]  = 1;
                end
            end
        end else if (!r[m_owner[k]]) begin
            m_owner[k] = -1;
        end else begin
            logic [3:0] others;
            others = r;
            others[m_owner[k]] = 1'b0;
            if (m_max[k] != 0 && m_held[k] >= m_max[k] && others != 4'd0) begin
                m_owner[k] = -1;
                if (m_pc[k] < 255) m_pc[k]++;
            end else begin
                m_held[k]++;
            end
        end
    endtask

    task automatic check_dut(input int k, input logic [3:0] g, input logic v,
                             input logic [1:0] id, input logic [7:0] pc);
        logic [3:0] eg;
        eg = (m_owner[k] >= 0) ? (4'd1 << m_owner[k]) : 4'd0;
        chk($sformatf("d%0d_gnt", k), 32'(g), 32'(eg));
        chk($sformatf("d%0d_valid", k), 32'(v), 32'(m_owner[k] >= 0));
        chk($sformatf("d%0d_id", k), 32'(id), (m_owner[k] >= 0) ? 32'(m_owner[k]) : 32'd0);
`ifdef RR_PREEMPT_STATS_EN
        chk($sformatf("d%0d_pcnt", k), 32'(pc), 32'(m_pc[k]));
`else
        if (pc !== 8'd0) chk($sformatf("d%0d_pcnt_tie", k), 32'(pc), 32'd0);
`endif
    endtask

    // One clock: drive at negedge, model at posedge, sample 1 time unit later.
    task automatic cycle(input bit rst_v, input logic [3:0] r);
        logic [7:0] pc8, pc0;
        reset = rst_v;
        {if8.req_3, if8.req_2, if8.req_1, if8.req_0} = r;
        {if0.req_3, if0.req_2, if0.req_1, if0.req_0} = r;
        @(posedge clock);
        model_step(0, rst_v, r);
        model_step(1, rst_v, r);
        #1;
`ifdef RR_PREEMPT_STATS_EN
        pc8 = if8.preempt_cnt;
        pc0 = if0.preempt_cnt;
`else
        pc8 = 8'd0;
        pc0 = 8'd0;
`endif
        check_dut(0, {if8.gnt_3, if8.gnt_2, if8.gnt_1, if8.gnt_0}, if8.gnt_valid, if8.gnt_id, pc8);
        check_dut(1, {if0.gnt_3, if0.gnt_2, if0.gnt_1, if0.gnt_0}, if0.gnt_valid, if0.gnt_id, pc0);
        @(negedge clock);
    endtask

    initial begin
        int cnt8;
        int cnt0;
        int order[$];
        logic [3:0] pending;
        logic [3:0] r;

        reset = 1'b0;
        {if8.req_3, if8.req_2, if8.req_1, if8.req_0} = 4'd0;
        {if0.req_3, if0.req_2, if0.req_1, if0.req_0} = 4'd0;
        @(negedge clock);

        // Reset then idle
        repeat (2) cycle(1'b0, 4'd0);
        repeat (5) cycle(1'b1, 4'd0);

        // Single agent, never preempted
        repeat (5) cycle(1'b1, 4'b0001);
        repeat (2) cycle(1'b1, 4'b0000);

        // Round robin from reset: each agent drops its request after being granted
        cycle(1'b0, 4'd0);
        pending = 4'hF;
        for (int c = 0; c < 12; c++) begin
            cycle(1'b1, pending);
            if (if8.gnt_valid) begin
                order.push_back(int'(if8.gnt_id));
                pending[if8.gnt_id] = 1'b0;
            end
        end
        chk("rr_count", 32'(order.size()), 32'd4);
        for (int i = 0; i < order.size(); i++) chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i));

        // Preemption: req_1 steady, req_2 joins at cycle 3
        cycle(1'b0, 4'd0);
        cnt8 = 0;
        cnt0 = 0;
        for (int c = 0; c < 12; c++) begin
            cycle(1'b1, (c >= 3) ? 4'b0110 : 4'b0010);
            if (if8.gnt_1) cnt8++;
            if (if0.gnt_1) cnt0++;
        end
        chk("preempt_hold8", 32'(cnt8), 32'd8);
        chk("preempt_gnt2", 32'(if8.gnt_2), 32'd1);
        chk("nohold_gnt1", 32'(cnt0), 32'd12);
`ifdef RR_PREEMPT_STATS_EN
        chk("preempt_cnt1", 32'(if8.preempt_cnt), 32'd1);
`endif

        // Reset mid-grant, then agent 0 beats agent 3
        cycle(1'b0, 4'd0);
        repeat (3) cycle(1'b1, 4'b1000);
        cycle(1'b0, 4'b1000);
        chk("rst_mid_valid", 32'(if8.gnt_valid), 32'd0);
        cycle(1'b1, 4'b1001);
        chk("rst_mid_gnt0", 32'(if8.gnt_0), 32'd1);

        // MAX_HOLD=0: agent 0 holds while both request
        cycle(1'b0, 4'd0);
        cnt0 = 0;
        repeat (20) begin
            cycle(1'b1, 4'b0011);
            if (if0.gnt_0) cnt0++;
        end
        chk("nohold_gnt0", 32'(cnt0), 32'd20);
        repeat (3) cycle(1'b1, 4'b0010);
        chk("nohold_then1", 32'(if0.gnt_1), 32'd1);

        // Random traffic with sticky requests and occasional resets
        r = 4'd0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            cycle(($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
